// File: rtl/adder_pipe_pkg.sv
// Shared constants and the elaboration-time configuration check for the
// pipelined adder/subtractor.
package adder_pipe_pkg;

  localparam int ADDER_PIPE_WIDTH  = 32;
  localparam int ADDER_PIPE_STAGES = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic bit stages_divide_width(input int width, input int stages);
    return (stages > 0) && (width > 0) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational W-bit ripple chain of full-adder cells; also exposes the
// carry into the top bit so the caller can derive signed overflow.
module adder_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         c_msb_in
);

  logic [W:0] carry_s;

  // Ripple the carry bit by bit through full-adder cells
  always_comb begin
    carry_s    = '0;
    s          = '0;
    carry_s[0] = ci;
    for (int i = 0; i < W; i++) begin
      s[i]         = a[i] ^ b[i] ^ carry_s[i];
      carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
    end
  end

  assign co       = carry_s[W];
  assign c_msb_in = carry_s[W-1];

endmodule

// File: rtl/adder_pipe_n.sv
// Pipelined ripple-carry adder/subtractor, one CHUNK resolved per stage with a
// global-stall valid/ready handshake. Define ADDER_PIPE_OVF_EN to add the ovf port.
module adder_pipe_n
  import adder_pipe_pkg::*;
#(
  parameter int WIDTH  = ADDER_PIPE_WIDTH,
  parameter int STAGES = ADDER_PIPE_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ADDER_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CHUNK = WIDTH / STAGES;

  if (!stages_divide_width(WIDTH, STAGES)) begin : g_cfg_err
    $error("adder_pipe_n: STAGES must divide WIDTH exactly");
  end

  logic                        adv_s;
  logic                        c0_s;
  logic [WIDTH-1:0]            b_eff_s;
  logic [STAGES-1:0][CHUNK-1:0] ch_a_s;
  logic [STAGES-1:0][CHUNK-1:0] ch_b_s;
  logic [STAGES-1:0][CHUNK-1:0] ch_s_s;
  logic [STAGES-1:0]           ch_ci_s;
  logic [STAGES-1:0]           ch_co_s;
  logic [STAGES-1:0]           ch_cm_s;
  logic                        unused_s;

  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] carry_q, carry_d;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];
`ifdef ADDER_PIPE_OVF_EN
  logic              ovf_q, ovf_d;
`endif

  // The whole pipeline moves together; it only freezes on a blocked result.
  assign adv_s     = ~valid_q[STAGES-1] | out_ready;
  assign in_ready  = adv_s;
  assign out_valid = valid_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = carry_q[STAGES-1];
`ifdef ADDER_PIPE_OVF_EN
  assign ovf       = ovf_q;
`endif

  // Operand conditioning and per-stage chunk operand selection
  always_comb begin
    c0_s       = (sub == OP_SUB) ? 1'b1 : cin;
    b_eff_s    = (sub == OP_ADD) ? B : ~B;
    ch_a_s     = '0;
    ch_b_s     = '0;
    ch_ci_s    = '0;
    ch_a_s[0]  = A[CHUNK-1:0];
    ch_b_s[0]  = b_eff_s[CHUNK-1:0];
    ch_ci_s[0] = c0_s;
    for (int k = 1; k < STAGES; k++) begin
      ch_a_s[k]  = a_q[k-1][k*CHUNK +: CHUNK];
      ch_b_s[k]  = b_q[k-1][k*CHUNK +: CHUNK];
      ch_ci_s[k] = carry_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_chunk #(.W(CHUNK)) u_chunk (
      .a        (ch_a_s[k]),
      .b        (ch_b_s[k]),
      .ci       (ch_ci_s[k]),
      .s        (ch_s_s[k]),
      .co       (ch_co_s[k]),
      .c_msb_in (ch_cm_s[k])
    );
  end

  // Next-state: shift every stage forward on advance, otherwise hold
  always_comb begin
    valid_d = valid_q;
    carry_d = carry_q;
    for (int k = 0; k < STAGES; k++) begin
      a_d[k] = a_q[k];
      b_d[k] = b_q[k];
      s_d[k] = s_q[k];
    end
`ifdef ADDER_PIPE_OVF_EN
    ovf_d = ovf_q;
`endif
    if (adv_s) begin
      valid_d[0]           = in_valid;
      a_d[0]               = A;
      b_d[0]               = b_eff_s;
      s_d[0]               = '0;
      s_d[0][CHUNK-1:0]    = ch_s_s[0];
      carry_d[0]           = ch_co_s[0];
      for (int k = 1; k < STAGES; k++) begin
        valid_d[k]               = valid_q[k-1];
        a_d[k]                   = a_q[k-1];
        b_d[k]                   = b_q[k-1];
        s_d[k]                   = s_q[k-1];
        s_d[k][k*CHUNK +: CHUNK] = ch_s_s[k];
        carry_d[k]               = ch_co_s[k];
      end
`ifdef ADDER_PIPE_OVF_EN
      ovf_d = ch_cm_s[STAGES-1] ^ ch_co_s[STAGES-1];
`endif
    end else begin
      valid_d = valid_q;
      carry_d = carry_q;
    end
  end

  // Operand bits already consumed by earlier stages are carried but never read
  always_comb begin
    unused_s = ^ch_cm_s;
    for (int k = 0; k < STAGES; k++) begin
      unused_s = unused_s ^ (^a_q[k]) ^ (^b_q[k]);
    end
  end

  // Stage registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      carry_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
`ifdef ADDER_PIPE_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
`ifdef ADDER_PIPE_OVF_EN
      ovf_q <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_adder_pipe_n.sv
// Self-checking bench for adder_pipe_n (WIDTH=32, STAGES=4): queue-based
// reference model plus directed scenarios and randomized traffic.
module tb_adder_pipe_n;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a_s = 32'd0;
  logic [31:0] b_s = 32'd0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] sum;
  logic        cout;
  logic        ovf_s;

  int tests = 0;
  int fails = 0;

  adder_pipe_n #(.WIDTH(32), .STAGES(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(a_s), .B(b_s), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef ADDER_PIPE_OVF_EN
    , .ovf(ovf_s)
`endif
  );
`ifndef ADDER_PIPE_OVF_EN
  assign ovf_s = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // {ovf, cout, sum} from plain wide arithmetic
  function automatic logic [33:0] calc(input logic [31:0] a, input logic [31:0] b,
                                       input logic ci, input logic sb);
    logic [31:0] bp;
    logic [32:0] t;
    logic        o;
    bp = sb ? ~b : b;
    t  = {1'b0, a} + {1'b0, bp} + {32'd0, (sb ? 1'b1 : ci)};
    o  = (a[31] == bp[31]) && (t[31] != a[31]);
    return {o, t};
  endfunction

  // Reference model: every accepted beat emerges after S advancing edges.
  typedef struct {
    logic [33:0] res;
    int          stamp;
  } ent_t;
  ent_t q[$];
  int   adv_n = 0;

  function automatic bit model_valid();
    return (q.size() > 0) && (adv_n - q[0].stamp == S - 1);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
    end else if (!model_valid() || out_ready) begin
      if (model_valid()) void'(q.pop_front());
      adv_n++;
      if (in_valid) q.push_back('{res: calc(a_s, b_s, cin, sub), stamp: adv_n});
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid", out_valid, model_valid());
      chk("in_ready", in_ready, !model_valid() || out_ready);
      if (model_valid()) begin
        chk("sum", sum, q[0].res[31:0]);
        chk("cout", cout, q[0].res[32]);
`ifdef ADDER_PIPE_OVF_EN
        chk("ovf", ovf_s, q[0].res[33]);
`endif
      end
    end
  end

  task automatic cyc(input logic iv, input logic [31:0] a, input logic [31:0] b,
                     input logic ci, input logic sb, input logic orr,
                     output logic acc, output logic rdy, output logic [31:0] s_at);
    in_valid = iv; a_s = a; b_s = b; cin = ci; sub = sb; out_ready = orr;
    @(negedge clk);
    rdy  = in_ready;
    acc  = iv & in_ready;
    s_at = sum;
    @(posedge clk); #1;
  endtask

  task automatic run_one(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic ci, input logic sb, input logic [31:0] es,
                         input logic ec, input logic eo);
    logic acc, rdy;
    logic [31:0] s_at;
    int lat;
    cyc(1'b1, a, b, ci, sb, 1'b1, acc, rdy, s_at);
    chk({nm, "_accept"}, acc, 1'b1);
    lat = 1;
    while (!out_valid && lat < 20) begin
      cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, acc, rdy, s_at);
      lat++;
    end
    chk({nm, "_latency"}, lat, S);
    chk({nm, "_sum"}, sum, es);
    chk({nm, "_cout"}, cout, ec);
`ifdef ADDER_PIPE_OVF_EN
    chk({nm, "_ovf"}, ovf_s, eo);
`else
    if (eo === 1'bx) $display("unexpected unknown");
`endif
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, acc, rdy, s_at);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc, rdy, pend, orr;
    logic [31:0] s_at, hold, ra, rb;
    logic rci, rsb;
    int j;
    logic [31:0] corners [4];
    corners = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};

    // Model pins
    chk("pin_wrap", calc(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0), {2'b01, 32'h0});
    chk("pin_borrow", calc(32'd5, 32'd7, 1'b1, 1'b1), {2'b00, 32'hFFFF_FFFE});
    chk("pin_ovf_pos", calc(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0), {2'b10, 32'h8000_0000});
    chk("pin_ovf_neg", calc(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0), {2'b11, 32'h0});

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_sum", sum, 32'h0);
    chk("rst_cout", cout, 1'b0);
    chk("rst_ovf", ovf_s, 1'b0);
    rst = 1'b0;

    run_one("t1", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    run_one("t2", 32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);

    // Back-to-back beats
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, i, 32'h10 * i, 1'b0, 1'b0, 1'b1, acc, rdy, s_at);
      chk("t3_in_ready", rdy, 1'b1);
    end
    repeat (6) cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, acc, rdy, s_at);

    // Stall with a full pipeline
    j = 0;
    hold = 32'd0;
    for (int k = 0; k < 20; k++) begin
      orr = !(k >= 6 && k <= 8);
      cyc(j < 8, 32'h1000 + j, j, 1'b0, 1'b0, orr, acc, rdy, s_at);
      if (k >= 6 && k <= 8) begin
        chk("t4_in_ready_low", rdy, 1'b0);
        if (k == 6) hold = s_at;
        chk("t4_sum_hold", sum, hold);
        chk("t4_valid_hold", out_valid, 1'b1);
      end
      if (acc) j++;
    end
    chk("t4_all_sent", j, 8);

    // Reset with beats in flight
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'd100 + i, 32'd1, 1'b0, 1'b0, 1'b1, acc, rdy, s_at);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t5_out_valid", out_valid, 1'b0);
    chk("t5_sum", sum, 32'h0);
    chk("t5_cout", cout, 1'b0);
    repeat (6) cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, acc, rdy, s_at);
    run_one("t5_new", 32'd2, 32'd3, 1'b0, 1'b0, 32'd5, 1'b0, 1'b0);

`ifdef ADDER_PIPE_OVF_EN
    run_one("t6_pos", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_one("t6_neg", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
`endif

    // Randomized traffic with backpressure
    pend = 1'b0;
    ra = 32'd0; rb = 32'd0; rci = 1'b0; rsb = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!pend) begin
        ra   = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
        rb   = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
        rci  = 1'($urandom_range(0, 1));
        rsb  = 1'($urandom_range(0, 1));
        pend = ($urandom_range(0, 3) != 0);
      end
      cyc(pend, ra, rb, rci, rsb, $urandom_range(0, 3) != 0, acc, rdy, s_at);
      if (acc) pend = 1'b0;
    end
    repeat (8) cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, acc, rdy, s_at);
    chk("drain_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
